register_file_mp: RTL and testbench

//  Parametrised multi-read-port integer register file for the RV32 core; successor to the 2R/1W file.

---
 rtl/register_file_mp.sv | 107 ++++++++++
 tb/tb_register_file_mp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-read-port integer register file with zero register, write-to-read bypass,
// per-register busy scoreboard and a sequential bulk-clear engine.
module register_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     wen,
  input  logic [AW-1:0]            waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     mark_en,
  input  logic [AW-1:0]            mark_idx,
  input  logic                     clr_req,
  output logic                     clr_active,
  output logic                     clr_done
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [AW-1:0]       cnt_q;
  logic                clr_done_q;

  logic wr_ok;
  logic mark_ok;

  // Writes and marks to register 0 are dropped when it is hardwired to zero.
  assign wr_ok   = wen && !((ZERO_REG != 0) && (waddr == '0));
  assign mark_ok = mark_en && !((ZERO_REG != 0) && (mark_idx == '0));

  // State update: writeback, scoreboard marks and the bulk-clear sweep.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (wr_ok) begin
            regs_q[waddr] <= wdata;
            busy_q[waddr] <= 1'b0;
          end
          // Mark after write so a same-cycle new producer leaves the register busy.
          if (mark_ok) begin
            busy_q[mark_idx] <= 1'b1;
          end
          if (clr_req) begin
            state_q <= StClear;
            cnt_q   <= '0;
          end
        end
        StClear: begin
          regs_q[cnt_q] <= '0;
          busy_q[cnt_q] <= 1'b0;
          // Counter wraps back to zero on the final step.
          cnt_q         <= cnt_q + 1'b1;
          if (cnt_q == AW'(NUM_REGS - 1)) begin
            state_q    <= StIdle;
            clr_done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign clr_active = (state_q == StClear);
  assign clr_done   = clr_done_q;

  // Combinational read ports: clear stall, zero register, bypass, then array.
  always_comb begin
    rdata   = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (state_q == StClear) begin
        rdata[i*DATA_W +: DATA_W] = '0;
        rd_busy[i]                = 1'b1;
      end else if ((ZERO_REG != 0) && (raddr[i*AW +: AW] == '0)) begin
        rdata[i*DATA_W +: DATA_W] = '0;
        rd_busy[i]                = 1'b0;
      end else if ((BYPASS != 0) && wen && (waddr == raddr[i*AW +: AW])) begin
        rdata[i*DATA_W +: DATA_W] = wdata;
        rd_busy[i]                = 1'b0;
      end else begin
        rdata[i*DATA_W +: DATA_W] = regs_q[raddr[i*AW +: AW]];
        rd_busy[i]                = busy_q[raddr[i*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: default instance plus a no-bypass,
// ordinary-register-0 instance driven from the same stimulus.
module tb_register_file_mp;

  logic        clk;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic        mark_en;
  logic [4:0]  mark_idx;
  logic        clr_req;

  logic [63:0] rdata,   rdata_a;
  logic [1:0]  rd_busy, rd_busy_a;
  logic        clr_active, clr_active_a;
  logic        clr_done,   clr_done_a;

  int n_tests = 0;
  int n_fail  = 0;

  register_file_mp dut (
    .CLK        (clk),
    .RST        (rst),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .rd_busy    (rd_busy),
    .mark_en    (mark_en),
    .mark_idx   (mark_idx),
    .clr_req    (clr_req),
    .clr_active (clr_active),
    .clr_done   (clr_done)
  );

  register_file_mp #(
    .BYPASS   (0),
    .ZERO_REG (0)
  ) dut_alt (
    .CLK        (clk),
    .RST        (rst),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata_a),
    .rd_busy    (rd_busy_a),
    .mark_en    (mark_en),
    .mark_idx   (mark_idx),
    .clr_req    (clr_req),
    .clr_active (clr_active_a),
    .clr_done   (clr_done_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic bad;
  int   cycles;

  initial begin
    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    mark_en = 1'b0; mark_idx = '0; clr_req = 1'b0;
    step();
    step();
    rst = 1'b0;
    raddr = {5'd3, 5'd5};
    #1;
    chk("reset_clr_active", {62'd0, clr_active, clr_active_a}, 64'd0);
    chk("reset_clr_done",   {62'd0, clr_done, clr_done_a}, 64'd0);
    chk("reset_rdata",      rdata | rdata_a, 64'd0);
    chk("reset_busy",       {60'd0, rd_busy, rd_busy_a}, 64'd0);

    // Basic write then dual read of the same index.
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    wen = 1'b0; raddr = {5'd5, 5'd5};
    #1;
    chk("x5_read_both", rdata, {32'hDEADBEEF, 32'hDEADBEEF});
    chk("x5_busy",      {62'd0, rd_busy}, 64'd0);

    // Register 0: hardwired in dut, ordinary in dut_alt.
    raddr = {5'd0, 5'd0};
    wen = 1'b1; waddr = 5'd0; wdata = 32'h1234;
    step();
    wen = 1'b0;
    #1;
    chk("x0_zero",     rdata, 64'd0);
    chk("x0_ordinary", rdata_a, {32'h1234, 32'h1234});

    // Same-cycle bypass vs old value.
    raddr = {5'd7, 5'd5};
    wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    #1;
    chk("bypass_on",      {32'd0, rdata[63:32]}, {32'd0, 32'hA5A5A5A5});
    chk("bypass_on_port0", {32'd0, rdata[31:0]}, {32'd0, 32'hDEADBEEF});
    chk("bypass_off",     {32'd0, rdata_a[63:32]}, 64'd0);
    step();
    wen = 1'b0;
    #1;
    chk("x7_after_write", {rdata[63:32], rdata_a[63:32]}, {32'hA5A5A5A5, 32'hA5A5A5A5});

    // Scoreboard: mark is visible only the next cycle.
    raddr = {5'd5, 5'd9};
    mark_en = 1'b1; mark_idx = 5'd9;
    #1;
    chk("mark_same_cycle", {62'd0, rd_busy[0], rd_busy_a[0]}, 64'd0);
    step();
    mark_en = 1'b0;
    #1;
    chk("mark_next_cycle", {62'd0, rd_busy[0], rd_busy_a[0]}, 64'd3);
    wen = 1'b1; waddr = 5'd9; wdata = 32'h99;
    #1;
    chk("wb_bypass_busy",  {62'd0, rd_busy[0], rd_busy_a[0]}, 64'd1);
    chk("wb_bypass_data",  {rdata[31:0], rdata_a[31:0]}, {32'h99, 32'h0});
    step();
    wen = 1'b0;
    #1;
    chk("wb_busy_cleared", {62'd0, rd_busy[0], rd_busy_a[0]}, 64'd0);
    mark_en = 1'b1; mark_idx = 5'd9;
    wen = 1'b1; waddr = 5'd9; wdata = 32'h77;
    step();
    mark_en = 1'b0; wen = 1'b0;
    #1;
    chk("mark_wins_busy", {62'd0, rd_busy[0], rd_busy_a[0]}, 64'd3);
    chk("mark_wins_data", {rdata[31:0], rdata_a[31:0]}, {32'h77, 32'h77});

    // Marking register 0: dropped in dut, honoured in dut_alt.
    mark_en = 1'b1; mark_idx = 5'd0;
    step();
    mark_en = 1'b0; raddr = {5'd0, 5'd0};
    #1;
    chk("mark_x0", {62'd0, rd_busy[0], rd_busy_a[0]}, 64'd1);

    // Fill x1..x31 with their own index.
    for (int i = 1; i < 32; i++) begin
      wen = 1'b1; waddr = 5'(i); wdata = 32'(i);
      step();
    end
    wen = 1'b0;
    raddr = {5'd31, 5'd17};
    #1;
    chk("fill_read", rdata, {32'd31, 32'd17});

    // Bulk clear with writes attempted throughout.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    wen = 1'b1; waddr = 5'd3; wdata = 32'hFFFF;
    raddr = {5'd3, 5'd17};
    bad = 1'b0;
    cycles = 0;
    while ((clr_active === 1'b1) && (cycles < 100)) begin
      if ((rd_busy !== 2'b11) || (rd_busy_a !== 2'b11) || (rdata !== 64'd0) ||
          (rdata_a !== 64'd0) || (clr_done !== 1'b0)) bad = 1'b1;
      step();
      cycles++;
    end
    wen = 1'b0;
    #1;
    chk("clr_cycles",     64'(cycles), 64'd32);
    chk("clr_stall",      {63'd0, bad}, 64'd0);
    chk("clr_done_pulse", {62'd0, clr_done, clr_done_a}, 64'd3);
    step();
    chk("clr_done_once",  {62'd0, clr_done, clr_done_a}, 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(i), 5'(i)};
      #1;
      if ((rdata | rdata_a) !== 64'd0 || (rd_busy | rd_busy_a) !== 2'b00) bad = 1'b1;
    end
    chk("clr_all_zero", {63'd0, bad}, 64'd0);

    // Reset in the middle of a clear aborts without clr_done.
    wen = 1'b1; waddr = 5'd20; wdata = 32'h20;
    step();
    wen = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    raddr = {5'd20, 5'd20};
    #1;
    chk("rst_abort_active", {62'd0, clr_active, clr_active_a}, 64'd0);
    chk("rst_abort_data",   rdata | rdata_a, 64'd0);
    bad = 1'b0;
    repeat (40) begin
      step();
      if (clr_done !== 1'b0 || clr_done_a !== 1'b0 || clr_active !== 1'b0) bad = 1'b1;
    end
    chk("rst_no_done", {63'd0, bad}, 64'd0);
    wen = 1'b1; waddr = 5'd20; wdata = 32'hABC;
    step();
    wen = 1'b0;
    #1;
    chk("post_rst_write", rdata, {32'hABC, 32'hABC});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
